// File: rtl/space_wire_time_code_scheduler.sv
// SpaceWire time-code scheduler: arbitrates host-requested and periodic auto
// time-codes onto the transmitter tick_in/time_in handshake, and registers
// received time-codes with a sequence check.
// Ports: i_clk/i_reset (sync, active-high); i_enable, i_link_running gate
// issuing; i_auto_period sets the auto-tick interval (0 = off); i_host_req/
// i_host_time/i_host_flags/o_host_ack form the host request path;
// o_tick_in/o_time_in/o_ctrl_flags_in/i_tx_ack form the transmitter handshake;
// o_busy flags an issue in flight or holdoff; i_rx_tick/i_rx_time feed the
// receive path, which drives o_rx_tick_out/o_rx_time_out/o_rx_seq_error.
module space_wire_time_code_scheduler #(
    parameter int PERIOD_W = 16,
    parameter int HOLDOFF  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_link_running,
    input  logic [PERIOD_W-1:0] i_auto_period,
    input  logic                i_host_req,
    input  logic [5:0]          i_host_time,
    input  logic [1:0]          i_host_flags,
    output logic                o_host_ack,
    output logic                o_tick_in,
    output logic [5:0]          o_time_in,
    output logic [1:0]          o_ctrl_flags_in,
    input  logic                i_tx_ack,
    output logic                o_busy,
    input  logic                i_rx_tick,
    input  logic [7:0]          i_rx_time,
    output logic                o_rx_tick_out,
    output logic [7:0]          o_rx_time_out,
    output logic                o_rx_seq_error
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] timer;
    logic                host_pending, auto_pending, served_host;
    logic [5:0]          host_time, local_time;
    logic [1:0]          host_flags;
    logic [HW-1:0]       hold_cnt;
    logic [5:0]          rx_prev;
    logic                rx_first;

    logic                run, timer_on, auto_expire;
    logic                tick_nxt, ack_nxt, served_nxt, take_host, take_auto;
    logic [5:0]          time_nxt, local_nxt;
    logic [1:0]          flags_nxt;
    logic [HW-1:0]       hold_nxt;

    assign run         = i_enable & i_link_running;
    assign timer_on    = run && (i_auto_period != '0);
    assign auto_expire = timer_on && (timer == i_auto_period - PERIOD_W'(1));
    assign o_busy      = (state != IDLE);

    // Next-state and registered-output values.
    always_comb begin
        state_nxt  = state;
        tick_nxt   = o_tick_in;
        time_nxt   = o_time_in;
        flags_nxt  = o_ctrl_flags_in;
        ack_nxt    = 1'b0;
        served_nxt = served_host;
        local_nxt  = local_time;
        hold_nxt   = hold_cnt;
        take_host  = 1'b0;
        take_auto  = 1'b0;
        if (!run) begin
            // Abandon any issue in flight; local_time keeps its last value.
            state_nxt = IDLE;
            tick_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_pending) begin
                        take_host  = 1'b1;
                        tick_nxt   = 1'b1;
                        time_nxt   = host_time;
                        flags_nxt  = host_flags;
                        local_nxt  = host_time;
                        served_nxt = 1'b1;
                        state_nxt  = ISSUE;
                    end else if (auto_pending) begin
                        take_auto  = 1'b1;
                        tick_nxt   = 1'b1;
                        time_nxt   = local_time + 6'd1;
                        flags_nxt  = 2'b00;
                        local_nxt  = local_time + 6'd1;
                        served_nxt = 1'b0;
                        state_nxt  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_tx_ack) begin
                        tick_nxt  = 1'b0;
                        ack_nxt   = served_host;
                        hold_nxt  = '0;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(HOLDOFF - 1)) state_nxt = IDLE;
                    else                              hold_nxt  = hold_cnt + HW'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            o_tick_in       <= 1'b0;
            o_time_in       <= '0;
            o_ctrl_flags_in <= '0;
            o_host_ack      <= 1'b0;
            served_host     <= 1'b0;
            local_time      <= '0;
            hold_cnt        <= '0;
        end else begin
            state           <= state_nxt;
            o_tick_in       <= tick_nxt;
            o_time_in       <= time_nxt;
            o_ctrl_flags_in <= flags_nxt;
            o_host_ack      <= ack_nxt;
            served_host     <= served_nxt;
            local_time      <= local_nxt;
            hold_cnt        <= hold_nxt;
        end
    end

    // Auto timer and pending flags. A fresh request wins over the clear from
    // being served in the same cycle so it is not lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timer        <= '0;
            host_pending <= 1'b0;
            auto_pending <= 1'b0;
            host_time    <= '0;
            host_flags   <= '0;
        end else begin
            // >= also catches a period shrunk below the running count.
            if (!timer_on || timer >= i_auto_period - PERIOD_W'(1))
                timer <= '0;
            else
                timer <= timer + PERIOD_W'(1);

            if (i_host_req) begin
                host_time  <= i_host_time;
                host_flags <= i_host_flags;
            end

            if (!run)            host_pending <= 1'b0;
            else if (i_host_req) host_pending <= 1'b1;
            else if (take_host)  host_pending <= 1'b0;

            if (!run)             auto_pending <= 1'b0;
            else if (auto_expire) auto_pending <= 1'b1;
            else if (take_auto)   auto_pending <= 1'b0;
        end
    end

    // Receive path, independent of the issue FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rx_tick_out  <= 1'b0;
            o_rx_time_out  <= '0;
            o_rx_seq_error <= 1'b0;
            rx_prev        <= '0;
            rx_first       <= 1'b1;
        end else begin
            o_rx_tick_out  <= i_rx_tick;
            o_rx_seq_error <= 1'b0;
            if (i_rx_tick) begin
                o_rx_time_out  <= i_rx_time;
                o_rx_seq_error <= !rx_first && (i_rx_time[5:0] != rx_prev + 6'd1);
                rx_prev        <= i_rx_time[5:0];
            end
            // Link loss restarts the sequence check.
            if (!i_link_running) rx_first <= 1'b1;
            else if (i_rx_tick)  rx_first <= 1'b0;
        end
    end

endmodule

// File: tb/tb_space_wire_time_code_scheduler.sv
module tb_space_wire_time_code_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, link;
    logic [15:0] period;
    logic        host_req;
    logic [5:0]  host_time;
    logic [1:0]  host_flags;
    logic        host_ack;
    logic        tick_in;
    logic [5:0]  time_in;
    logic [1:0]  flags_in;
    logic        tx_ack;
    logic        busy;
    logic        rx_tick;
    logic [7:0]  rx_time;
    logic        rx_tick_out;
    logic [7:0]  rx_time_out;
    logic        rx_seq_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    space_wire_time_code_scheduler #(.PERIOD_W(16), .HOLDOFF(4)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (enable),
        .i_link_running  (link),
        .i_auto_period   (period),
        .i_host_req      (host_req),
        .i_host_time     (host_time),
        .i_host_flags    (host_flags),
        .o_host_ack      (host_ack),
        .o_tick_in       (tick_in),
        .o_time_in       (time_in),
        .o_ctrl_flags_in (flags_in),
        .i_tx_ack        (tx_ack),
        .o_busy          (busy),
        .i_rx_tick       (rx_tick),
        .i_rx_time       (rx_time),
        .o_rx_tick_out   (rx_tick_out),
        .o_rx_time_out   (rx_time_out),
        .o_rx_seq_error  (rx_seq_error)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_tick(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (tick_in) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for tick_in, capture the code, ack two cycles after the rise.
    // Returns on the negedge where tick_in has just fallen.
    task automatic serve(output logic [5:0] t, output logic [1:0] f, output int at);
        logic ok;
        wait_tick(40, ok);
        check("tick_timeout", {31'd0, ok}, 32'd1);
        t  = time_in;
        f  = flags_in;
        at = cyc;
        if (!ok) return;
        @(negedge clk);
        check("tick_held", {31'd0, tick_in}, 32'd1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] v);
        rx_tick = 1'b1;
        rx_time = v;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    logic [5:0] t;
    logic [1:0] f;
    int         at, prev_at, seen;
    logic       ok;

    initial begin
        rst = 1'b1; enable = 1'b1; link = 1'b1; period = 16'd10;
        host_req = 1'b0; host_time = '0; host_flags = '0;
        tx_ack = 1'b0; rx_tick = 1'b0; rx_time = '0;
        repeat (3) @(negedge clk);
        check("rst_tick",   {31'd0, tick_in}, 32'd0);
        check("rst_time",   {26'd0, time_in}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_ack",    {31'd0, host_ack}, 32'd0);
        check("rst_rxtick", {31'd0, rx_tick_out}, 32'd0);
        check("rst_rxtime", {24'd0, rx_time_out}, 32'd0);
        rst = 1'b0;

        // Auto ticks every 10 cycles, time 1,2,3, flags 00, busy for ack+holdoff.
        serve(t, f, at);
        check("auto1_time", {26'd0, t}, 32'd1);
        check("auto1_flags", {30'd0, f}, 32'd0);
        check("ack_tick_fall", {31'd0, tick_in}, 32'd0);
        check("auto_no_hack", {31'd0, host_ack}, 32'd0);
        check("busy_hold0", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("busy_hold3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        prev_at = at;
        for (int e = 2; e <= 3; e++) begin
            serve(t, f, at);
            check("auto_time", {26'd0, t}, e);
            check("auto_interval", at - prev_at, 32'd10);
            prev_at = at;
        end

        // Run up to 63, then wrap to 0; loop the codes back through rx.
        for (int e = 4; e <= 63; e++) begin
            serve(t, f, at);
            check("auto_seq", {26'd0, t}, e);
        end
        rx_send({2'b00, t});
        serve(t, f, at);
        check("auto_wrap", {26'd0, t}, 32'd0);
        rx_send({2'b00, t});
        check("rx_wrap_tick", {31'd0, rx_tick_out}, 32'd1);
        check("rx_wrap_err", {31'd0, rx_seq_error}, 32'd0);

        // Host request on the same cycle as the next auto expiry (at+9).
        while (cyc < at + 8) @(negedge clk);
        host_req = 1'b1; host_time = 6'h20; host_flags = 2'b10;
        @(negedge clk);
        host_req = 1'b0;
        serve(t, f, at);
        check("host_time", {26'd0, t}, 32'h20);
        check("host_flags", {30'd0, f}, 32'd2);
        check("host_ack", {31'd0, host_ack}, 32'd1);
        check("host_tick_fall", {31'd0, tick_in}, 32'd0);
        @(negedge clk);
        check("host_ack_pulse", {31'd0, host_ack}, 32'd0);
        serve(t, f, at);
        check("after_host_time", {26'd0, t}, 32'h21);
        check("after_host_flags", {30'd0, f}, 32'd0);
        check("after_host_noack", {31'd0, host_ack}, 32'd0);

        // Drop link during an un-acked host issue.
        host_req = 1'b1; host_time = 6'h05; host_flags = 2'b01;
        @(negedge clk);
        host_req = 1'b0;
        wait_tick(40, ok);
        check("drop_tick_seen", {31'd0, ok}, 32'd1);
        check("drop_issue_time", {26'd0, time_in}, 32'h05);
        link = 1'b0;
        @(negedge clk);
        check("drop_tick", {31'd0, tick_in}, 32'd0);
        check("drop_hack", {31'd0, host_ack}, 32'd0);
        check("drop_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("drop_hack2", {31'd0, host_ack}, 32'd0);
        link = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (tick_in) seen++;
        end
        check("no_stale_issue", seen, 32'd0);
        serve(t, f, at);
        check("resume_time", {26'd0, t}, 32'd6);

        // Auto-tick disabled: nothing issues, stray tx_ack is ignored.
        link = 1'b0; period = 16'd0;
        repeat (2) @(negedge clk);
        link = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tx_ack = (i == 50);
            @(negedge clk);
            if (tick_in || busy) seen++;
        end
        tx_ack = 1'b0;
        check("period0_quiet", seen, 32'd0);

        // Rx sequence check: 5,6,8 -> error only on 8.
        rx_send(8'h45);
        check("rx5_tick", {31'd0, rx_tick_out}, 32'd1);
        check("rx5_time", {24'd0, rx_time_out}, 32'h45);
        check("rx5_err", {31'd0, rx_seq_error}, 32'd0);
        rx_send(8'h06);
        check("rx6_tick", {31'd0, rx_tick_out}, 32'd1);
        check("rx6_err", {31'd0, rx_seq_error}, 32'd0);
        rx_send(8'h08);
        check("rx8_tick", {31'd0, rx_tick_out}, 32'd1);
        check("rx8_time", {24'd0, rx_time_out}, 32'h08);
        check("rx8_err", {31'd0, rx_seq_error}, 32'd1);
        @(negedge clk);
        check("rx_tick_pulse", {31'd0, rx_tick_out}, 32'd0);
        check("rx_err_pulse", {31'd0, rx_seq_error}, 32'd0);
        check("rx_time_hold", {24'd0, rx_time_out}, 32'h08);
        link = 1'b0;
        @(negedge clk);
        link = 1'b1;
        rx_send(8'd40);
        check("rx40_tick", {31'd0, rx_tick_out}, 32'd1);
        check("rx40_time", {24'd0, rx_time_out}, 32'd40);
        check("rx40_err", {31'd0, rx_seq_error}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/space_wire_time_code_scheduler.md
Name: space_wire_time_code_scheduler

Overview:
- Schedules SpaceWire time-code transmission and checks received time-codes.
- Arbitrates between a host-requested time-code and an internal periodic auto-tick, and drives the transmitter tick_in/time_in handshake.
- On the receive side, accepts the already-synchronized single-cycle rx tick pulse, registers the time value and flags sequence errors.

Parameters:
- PERIOD_W, 16, width of the auto-tick period counter and of i_auto_period.
- HOLDOFF, 4, minimum idle cycles between two issued time-codes (≥1).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous reset, active-high.
- i_enable  in  1  scheduler enable; 0 = no new issues, auto timer held at 0.
- i_link_running  in  1  link FSM in Run state.
- i_auto_period  in  PERIOD_W  auto-tick interval in cycles; 0 disables auto-tick.
- i_host_req  in  1  single-cycle host request to send i_host_time.
- i_host_time  in  6  host time value, captured with i_host_req.
- i_host_flags  in  2  host control flags, captured with i_host_req.
- o_host_ack  out  1  one-cycle pulse when the host code is accepted by the transmitter.
- o_tick_in  out  1  request to transmitter; held high until i_tx_ack.
- o_time_in  out  6  time value to transmit; stable while o_tick_in is high.
- o_ctrl_flags_in  out  2  flags to transmit; stable while o_tick_in is high.
- i_tx_ack  in  1  transmitter accepted the time-code (single cycle).
- o_busy  out  1  high in ISSUE or HOLDOFF.
- i_rx_tick  in  1  synchronized single-cycle rx time-code pulse.
- i_rx_time  in  8  rx time-code: [7:6] flags, [5:0] time.
- o_rx_tick_out  out  1  registered rx tick, one cycle after i_rx_tick.
- o_rx_time_out  out  8  last received time-code, updated with o_rx_tick_out.
- o_rx_seq_error  out  1  one-cycle pulse with o_rx_tick_out when rx time ≠ previous+1 mod 64.

Behaviour:
- Reset (i_reset=1 at the i_clk edge): all outputs 0, FSM=IDLE, local time counter=0, auto timer=0, host_pending=0, auto_pending=0, rx_first=1.
- Auto timer: counts while i_enable & i_link_running & i_auto_period≠0.
  - At count==i_auto_period-1 it sets auto_pending and reloads 0.
  - Any other condition holds the timer at 0.
  - A period change takes effect on the next compare. If the counter is already ≥ the new period, the timer reloads 0 without setting pending.
- i_host_req sets host_pending and captures time/flags.
  - A second request while host_pending=1 overwrites the captured values; still one ack.
- FSM IDLE: requires i_enable & i_link_running. Host_pending has priority over auto_pending.
  - Host selected: o_time_in=captured time, o_ctrl_flags_in=captured flags; local counter loads captured time; host_pending cleared.
  - Auto selected: o_time_in=(local counter+1) mod 64, o_ctrl_flags_in=00; local counter increments (63 wraps to 0); auto_pending cleared.
  - Either case: o_tick_in=1 next cycle → ISSUE.
- FSM ISSUE: o_tick_in held at 1.
  - On i_tx_ack: o_tick_in=0 the next cycle, → HOLDOFF.
  - If the served request was host: o_host_ack pulses one cycle, coincident with o_tick_in falling.
- FSM HOLDOFF: count HOLDOFF cycles, then → IDLE. Requests arriving here stay pending (auto_pending is one bit; multiple expiries collapse to one issue).
- Simultaneous host_req and auto expiry in IDLE: host served first, auto served after holdoff.
- i_link_running=0 or i_enable=0 in any state:
  - Next cycle: o_tick_in=0, FSM=IDLE, host_pending and auto_pending cleared, no o_host_ack.
  - Local counter keeps its last issued value.
- i_tx_ack outside ISSUE is ignored.
- Rx path, independent of the FSM: on i_rx_tick, next cycle o_rx_tick_out=1 and o_rx_time_out=i_rx_time.
  - o_rx_seq_error=1 if rx_first=0 and i_rx_time[5:0] ≠ (previous rx time+1) mod 64.
  - rx_first is cleared by the first tick. rx_first is set when i_link_running=0 or on reset.
  - 63→0 is in sequence.

Test Plan:
- Reset, i_enable=1, link up, i_auto_period=10, tx_ack 2 cycles after each tick_in → tick_in every 10 cycles, time_in=1,2,3…, flags=00, busy during issue+4 holdoff.
- Run auto to 63 → next time_in=0, no error on loopback rx 63→0.
- host_req time=0x20 flags=10 on the same cycle as an auto expiry → host code sent first (0x20, flags 10), o_host_ack with tick_in fall; auto code 0x21 follows after holdoff.
- Drop i_link_running while o_tick_in=1 and no ack → tick_in 0 next cycle, no host_ack, FSM IDLE; re-raise link → no stale pending issue.
- i_auto_period=0, no host_req for 200 cycles → o_tick_in stays 0.
- Rx ticks 5,6,8 → o_rx_tick_out three pulses, o_rx_seq_error only with 8. Drop link, then rx 40 → no error.
